// File: rtl/mcu_isp_bridge.sv
// MCU shell between a host UART and an SPI NOR flash: boots a 4-byte word, then echoes or tunnels ISP commands.
// Optional: define MCU_ECHO_EN to retransmit every normal-mode UART byte.
module mcu_isp_bridge #(
  parameter int unsigned FLASH_ABITS = 24,
  parameter int unsigned BAUD_DIV    = 32,
  parameter int unsigned BOOT_ADDR   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic       sclk,
  output logic       cs_n,
  input  logic [3:0] qdi,
  output logic [3:0] qdo,
  output logic [3:0] oe
);

  localparam int unsigned NAB   = FLASH_ABITS / 8;
  localparam int unsigned HALF  = BAUD_DIV / 2;
  localparam int unsigned CW    = $clog2(BAUD_DIV + 1);
  localparam logic [31:0] ABUF0 = 32'(BOOT_ADDR) << (32 - FLASH_ABITS);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_PING, S_WR, S_RD, S_RDTX
  } state_t;

  state_t state, state_d;
  logic cs_n_d, isp, isp_d, wr_pend, wr_pend_d, esc, esc_d;
  logic [31:0] bw, bw_d, abuf, abuf_d;
  logic [5:0] rcnt, rcnt_d;
  logic [1:0] mat, mat_d, idx, idx_d;
  logic rx_take_c, tx_start_c, spi_start_c;
  logic [7:0] tx_byte_c, spi_byte_c;

  logic unused_qdi;
  assign unused_qdi = ^{qdi[3:2], qdi[0]};

  // UART receiver: start validated at mid-bit, data and stop sampled mid-bit
  logic rx_s1, rx_s2, rx_busy, rx_valid, rx_pend;
  logic [3:0] rx_bit;
  logic [CW-1:0] rx_cnt;
  logic [7:0] rx_sh, rx_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_busy <= 1'b0; rx_valid <= 1'b0;
      rx_bit <= 4'd0; rx_cnt <= '0; rx_sh <= 8'h00;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        rx_cnt <= '0;
        rx_bit <= 4'd0;
        if (!rx_s2) rx_busy <= 1'b1;
      end else if (rx_cnt == ((rx_bit == 4'd0) ? CW'(HALF - 1) : CW'(BAUD_DIV - 1))) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_s2;
        end else begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // One-byte holding register so bytes arriving during a stall are kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pend <= 1'b0; rx_hold <= 8'h00;
    end else if (rx_valid) begin
      rx_pend <= 1'b1; rx_hold <= rx_sh;
    end else if (rx_take_c) begin
      rx_pend <= 1'b0;
    end
  end

  // UART transmitter
  logic tx_busy;
  logic [8:0] tx_sh;
  logic [3:0] tx_bit;
  logic [CW-1:0] tx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd <= 1'b1; tx_busy <= 1'b0; tx_sh <= 9'h1FF; tx_bit <= 4'd0; tx_cnt <= '0;
    end else if (tx_start_c) begin
      txd <= 1'b0; tx_busy <= 1'b1; tx_sh <= {1'b1, tx_byte_c}; tx_bit <= 4'd0; tx_cnt <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == CW'(BAUD_DIV - 1)) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          txd    <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  // SPI mode-0 byte engine, sclk = clk/2, 16 clocks per byte
  logic spi_busy, spi_done, mosi;
  logic [6:0] spi_sh;
  logic [7:0] spi_rx;
  logic [3:0] spi_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0; mosi <= 1'b0; spi_busy <= 1'b0; spi_done <= 1'b0;
      spi_sh <= 7'h00; spi_rx <= 8'h00; spi_cnt <= 4'd0;
    end else begin
      spi_done <= 1'b0;
      if (spi_start_c) begin
        spi_busy <= 1'b1; spi_cnt <= 4'd0;
        mosi <= spi_byte_c[7]; spi_sh <= spi_byte_c[6:0];
      end else if (spi_busy) begin
        spi_cnt <= spi_cnt + 4'd1;
        if (!spi_cnt[0]) begin
          sclk   <= 1'b1;
          spi_rx <= {spi_rx[6:0], qdi[1]};
        end else begin
          sclk   <= 1'b0;
          mosi   <= spi_sh[6];
          spi_sh <= {spi_sh[5:0], 1'b0};
          if (spi_cnt == 4'd15) begin
            spi_busy <= 1'b0;
            spi_done <= 1'b1;
          end
        end
      end
    end
  end

  assign qdo = {2'b11, 1'b0, mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; cs_n <= 1'b1; oe <= 4'b0000; isp <= 1'b0; bw <= 32'h0;
      rcnt <= 6'd0; mat <= 2'd0; wr_pend <= 1'b0; esc <= 1'b0; idx <= 2'd0; abuf <= ABUF0;
    end else begin
      state <= state_d; cs_n <= cs_n_d; oe <= cs_n_d ? 4'b0000 : 4'b1101;
      isp <= isp_d; bw <= bw_d; rcnt <= rcnt_d; mat <= mat_d;
      wr_pend <= wr_pend_d; esc <= esc_d; idx <= idx_d; abuf <= abuf_d;
    end
  end

  // Boot sequence, then normal/ISP byte handling
  always_comb begin
    state_d = state; cs_n_d = cs_n; isp_d = isp; bw_d = bw; rcnt_d = rcnt; mat_d = mat;
    wr_pend_d = wr_pend; esc_d = esc; idx_d = idx; abuf_d = abuf;
    rx_take_c = 1'b0; tx_start_c = 1'b0; tx_byte_c = rx_hold;
    spi_start_c = 1'b0; spi_byte_c = 8'hFF;
    case (state)
      S_IDLE: begin
        rx_take_c = rx_pend;
        cs_n_d = 1'b0; spi_start_c = 1'b1; spi_byte_c = 8'h03;
        idx_d = 2'd0; abuf_d = ABUF0; state_d = S_CMD;
      end
      S_CMD: begin
        rx_take_c = rx_pend;
        if (spi_done) begin
          spi_start_c = 1'b1; spi_byte_c = abuf[31:24];
          abuf_d = {abuf[23:0], 8'h00}; state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        rx_take_c = rx_pend;
        if (spi_done) begin
          spi_start_c = 1'b1;
          if (idx == 2'(NAB - 1)) begin
            idx_d = 2'd0; state_d = S_DATA;
          end else begin
            spi_byte_c = abuf[31:24]; abuf_d = {abuf[23:0], 8'h00}; idx_d = idx + 2'd1;
          end
        end
      end
      S_DATA: begin
        rx_take_c = rx_pend;
        if (spi_done) begin
          bw_d = {bw[23:0], spi_rx};
          if (idx == 2'd3) begin
            cs_n_d = 1'b1; state_d = S_DONE;
          end else begin
            spi_start_c = 1'b1; idx_d = idx + 2'd1;
          end
        end
      end
      S_DONE: begin
        if (rx_pend && !tx_busy) begin
          rx_take_c = 1'b1;
          if (!isp) begin
`ifdef MCU_ECHO_EN
            tx_start_c = 1'b1;
`else
            tx_start_c = 1'b0;
`endif
            if (mat == 2'd2 && rx_hold == 8'h5A) begin
              isp_d = 1'b1; mat_d = 2'd0; esc_d = 1'b0; wr_pend_d = 1'b0;
            end else if (rx_hold == 8'h12)                 mat_d = 2'd1;
            else if (mat == 2'd1 && rx_hold == 8'hA5)      mat_d = 2'd2;
            else                                           mat_d = 2'd0;
          end else if (wr_pend) begin
            wr_pend_d = 1'b0; spi_start_c = 1'b1; spi_byte_c = rx_hold; state_d = S_WR;
          end else if (esc) begin
            esc_d = 1'b0;
            if (rx_hold == 8'h00) begin
              isp_d = 1'b0; cs_n_d = 1'b1;
            end
          end else begin
            case (rx_hold)
              8'h12: esc_d = 1'b1;
              8'h42: begin idx_d = 2'd0; state_d = S_PING; end
              8'h80: cs_n_d = 1'b1;
              8'h82: begin cs_n_d = 1'b0; wr_pend_d = 1'b1; end
              8'hC2: begin cs_n_d = 1'b0; spi_start_c = 1'b1; state_d = S_RD; end
              default: if (rx_hold >= 8'h01 && rx_hold <= 8'h3F) rcnt_d = rx_hold[5:0];
            endcase
          end
        end
      end
      S_PING: begin
        if (!tx_busy) begin
          tx_start_c = 1'b1;
          case (idx)
            2'd0:    tx_byte_c = bw[31:24];
            2'd1:    tx_byte_c = bw[23:16];
            2'd2:    tx_byte_c = bw[15:8];
            default: tx_byte_c = bw[7:0];
          endcase
          idx_d = idx + 2'd1;
          if (idx == 2'd3) state_d = S_DONE;
        end
      end
      S_WR: if (spi_done) state_d = S_DONE;
      S_RD: if (spi_done) state_d = S_RDTX;
      S_RDTX: begin
        // Forward the byte only once the transmitter is free, then start the next read
        if (!tx_busy) begin
          tx_start_c = 1'b1; tx_byte_c = spi_rx;
          if (rcnt == 6'd0) begin
            state_d = S_DONE;
          end else begin
            rcnt_d = rcnt - 6'd1; spi_start_c = 1'b1; state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcu_isp_bridge.sv
// Directed bench for mcu_isp_bridge with a behavioural SPI flash and UART host.
module tb_mcu_isp_bridge;
  localparam int BD = 32;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
  logic txd, sclk, cs_n;
  logic [3:0] qdi, qdo, oe;
  int n_chk = 0, n_fail = 0, cs_rise = 0;
  bq_t tx_q, mosi_q;

  always #5 clk = ~clk;

  mcu_isp_bridge dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd), .sclk(sclk),
    .cs_n(cs_n), .qdi(qdi), .qdo(qdo), .oe(oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input bq_t got, input int base, input bq_t exp);
    foreach (exp[i])
      check($sformatf("%s[%0d]", tag, i),
            (base + i < got.size()) ? 32'(got[base + i]) : 32'hDEAD_BEEF, 32'(exp[i]));
  endtask

  // Flash model: S25FL-like READ (03), JEDEC ID (9F), status (05)
  logic miso = 1'b1;
  logic [7:0] fl_in = 8'h00, fl_out = 8'hFF, fl_cmd = 8'h00;
  int fl_bits = 0;
  logic [7:0] fl_mem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  assign qdi = {2'b11, miso, 1'b1};

  function automatic logic [7:0] fl_byte(input logic [7:0] cmd, input int n);
    case (cmd)
      8'h03: return (n >= 4 && n < 8) ? fl_mem[n - 4] : 8'hFF;
      8'h9F: return (n == 1) ? 8'h01 : (n == 2) ? 8'h60 : (n == 3) ? 8'h17 : 8'hFF;
      8'h05: return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  always @(negedge cs_n) fl_bits = 0;
  always @(posedge cs_n) cs_rise++;

  always @(posedge sclk) begin
    if (cs_n === 1'b0) begin
      fl_in = {fl_in[6:0], qdo[0]};
      fl_bits++;
      if (fl_bits % 8 == 0) begin
        if (fl_bits == 8) fl_cmd = fl_in;
        mosi_q.push_back(fl_in);
        fl_out = fl_byte(fl_cmd, fl_bits / 8);
      end
    end
  end

  always @(negedge sclk) begin
    if (cs_n === 1'b0) begin
      miso = fl_out[7];
      fl_out = {fl_out[6:0], 1'b1};
    end
  end

  // UART host receiver
  always begin
    @(negedge txd);
    repeat (BD / 2) @(posedge clk);
    if (txd == 1'b0) begin
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(posedge clk);
        b[i] = txd;
      end
      repeat (BD) @(posedge clk);
      tx_q.push_back(b);
    end
  end

  task automatic uart_send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BD) @(negedge clk);
    end
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) uart_send(s[i]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_boot(input int mb);
    int k = 0;
    while (!(cs_n === 1'b1 && mosi_q.size() >= mb + 8) && k < 2000) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    bq_t e;
    int mb, tb0, cr;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_qdo", 32'(qdo), 32'hC);
    check("rst_oe", 32'(oe), 0);

    mb = mosi_q.size();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("boot_cs_low", 32'(cs_n), 0);
    check("boot_oe", 32'(oe), 32'hD);
    check("boot_qdo_hi", 32'(qdo[3:2]), 3);
    wait_boot(mb);
    check("boot_nbytes", 32'(mosi_q.size() - mb), 8);
    e = '{8'h03, 8'h00, 8'h00, 8'h00};
    check_bytes("boot_mosi", mosi_q, mb, e);
    check("boot_cs_high", 32'(cs_n), 1);
    check("boot_oe_off", 32'(oe), 0);
    check("boot_no_tx", 32'(tx_q.size()), 0);

    // Activation and ping
    tb0 = tx_q.size();
`ifdef MCU_ECHO_EN
    e = '{8'h12, 8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
`else
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    send_seq('{8'h12, 8'hA5, 8'h5A, 8'h42});
    wait_tx(tb0 + e.size(), 6000);
    repeat (50) @(negedge clk);
    check("ping_len", 32'(tx_q.size() - tb0), 32'(e.size()));
    check_bytes("ping", tx_q, tb0, e);

    // JEDEC ID via write + 3-byte read
    tb0 = tx_q.size(); mb = mosi_q.size();
    send_seq('{8'h00, 8'h00, 8'h82, 8'h9F, 8'h02, 8'hC2, 8'h80});
    wait_tx(tb0 + 3, 4000);
    repeat (400) @(negedge clk);
    check("jedec_len", 32'(tx_q.size() - tb0), 3);
    e = '{8'h01, 8'h60, 8'h17};
    check_bytes("jedec", tx_q, tb0, e);
    check("jedec_mosi_len", 32'(mosi_q.size() - mb), 4);
    e = '{8'h9F, 8'hFF, 8'hFF, 8'hFF};
    check_bytes("jedec_mosi", mosi_q, mb, e);
    check("jedec_cs_high", 32'(cs_n), 1);
    check("jedec_oe_off", 32'(oe), 0);

    // Status reads with R back to 0 and cs_n held low
    cr = cs_rise; mb = mosi_q.size();
    for (int r = 0; r < 3; r++) begin
      tb0 = tx_q.size();
      if (r == 0) send_seq('{8'h82, 8'h05, 8'hC2});
      else        send_seq('{8'hC2});
      wait_tx(tb0 + 1, 3000);
      repeat (400) @(negedge clk);
      check($sformatf("stat%0d_len", r), 32'(tx_q.size() - tb0), 1);
      e = '{8'h00};
      check_bytes($sformatf("stat%0d", r), tx_q, tb0, e);
      check($sformatf("stat%0d_cs_low", r), 32'(cs_n), 0);
      check($sformatf("stat%0d_oe", r), 32'(oe), 32'hD);
    end
    check("stat_cs_rises", 32'(cs_rise - cr), 0);
    check("stat_mosi_len", 32'(mosi_q.size() - mb), 4);

    // Deselect, escape out of ISP, then normal-mode traffic
    tb0 = tx_q.size();
    send_seq('{8'h80, 8'h12, 8'h00, 8'h41, 8'h42});
    repeat (800) @(negedge clk);
`ifdef MCU_ECHO_EN
    e = '{8'h41, 8'h42};
`else
    e = {};
`endif
    check("exit_len", 32'(tx_q.size() - tb0), 32'(e.size()));
    check_bytes("exit", tx_q, tb0, e);
    check("exit_cs_high", 32'(cs_n), 1);

    // Reset in the middle of a boot SPI byte
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100 && sclk !== 1'b1; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 1);
    check("mid_rst_oe", 32'(oe), 0);
    check("mid_rst_txd", 32'(txd), 1);
    check("mid_rst_sclk", 32'(sclk), 0);
    repeat (3) @(negedge clk);
    mb = mosi_q.size();
    rst_n = 1'b1;
    wait_boot(mb);
    check("reboot_nbytes", 32'(mosi_q.size() - mb), 8);
    e = '{8'h03, 8'h00, 8'h00, 8'h00};
    check_bytes("reboot_mosi", mosi_q, mb, e);

    tb0 = tx_q.size();
`ifdef MCU_ECHO_EN
    e = '{8'h12, 8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
`else
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    send_seq('{8'h12, 8'hA5, 8'h5A, 8'h42});
    wait_tx(tb0 + e.size(), 6000);
    repeat (50) @(negedge clk);
    check("reping_len", 32'(tx_q.size() - tb0), 32'(e.size()));
    check_bytes("reping", tx_q, tb0, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
